// File: rtl/fetch_sequencer_if.sv
// Handshake and memory bus bundle between the fetch sequencer, the byte-wide
// instruction memory, branch/redirect logic and the decode stage.
interface fetch_sequencer_if;
    logic        fetch_en;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_rd;
    logic [63:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;
    logic        busy;

    modport master (
        input  fetch_en, redirect_valid, redirect_pc, mem_rdata, inst_ready,
        output mem_rd, mem_addr, inst_valid, inst, inst_pc, busy
    );

    modport slave (
        output fetch_en, redirect_valid, redirect_pc, mem_rdata, inst_ready,
        input  mem_rd, mem_addr, inst_valid, inst, inst_pc, busy
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: issues four byte reads per instruction, assembles
// them little-endian and hands the word to decode over a valid/ready handshake.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, VALID} state_t;

    state_t            state_q, state_d;
    logic [63:0]       pc_q, pc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic              cap_vld_q, cap_vld_d;
    logic [3:0][7:0]   buf_q, buf_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            cnt_q     <= 2'd0;
            cap_idx_q <= 2'd0;
            cap_vld_q <= 1'b0;
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            cap_idx_q <= cap_idx_d;
            cap_vld_q <= cap_vld_d;
            buf_q     <= buf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        cap_idx_d = cap_idx_q;
        cap_vld_d = cap_vld_q;
        buf_d     = buf_q;

        // The byte requested last cycle is on mem_rdata now; a redirect discards it.
        if (cap_vld_q && !bus.redirect_valid) begin
            buf_d[cap_idx_q] = bus.mem_rdata;
        end

        if (bus.redirect_valid) begin
            pc_d      = {bus.redirect_pc[63:2], 2'b00};
            cnt_d     = 2'd0;
            cap_vld_d = 1'b0;
            state_d   = bus.fetch_en ? FETCH : IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.fetch_en) begin
                        cnt_d   = 2'd0;
                        state_d = FETCH;
                    end
                end
                FETCH: begin
                    cap_idx_d = cnt_q;
                    cap_vld_d = 1'b1;
                    cnt_d     = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    cap_vld_d = 1'b0;
                    state_d   = VALID;
                end
                VALID: begin
                    if (bus.inst_ready) begin
                        pc_d    = pc_q + 64'd4;
                        cnt_d   = 2'd0;
                        state_d = bus.fetch_en ? FETCH : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory-side outputs come from registers only, so no combinational path
    // from inst_ready or redirect_valid reaches the memory.
    assign bus.mem_rd     = (state_q == FETCH);
    assign bus.mem_addr   = pc_q + {62'd0, cnt_q};
    assign bus.inst_valid = (state_q == VALID);
    assign bus.inst       = buf_q;
    assign bus.inst_pc    = pc_q;
    assign bus.busy       = (state_q == FETCH) || (state_q == DRAIN);
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller between the byte-wide instruction memory and the decode stage. It holds the fetch PC and issues four byte reads per instruction at PC+0..PC+3. It assembles the bytes little-endian into a 32-bit word and presents it to decode with a valid/ready handshake. Branch/jump logic can redirect it at any time, and redirect aborts any fetch in flight.

## Interface
- RESET_PC, 64'd0, fetch PC loaded on reset
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- fetch_en  in  1  permit starting new fetches
- redirect_valid  in  1  load new PC, abort current fetch
- redirect_pc  in  64  redirect target; bits [1:0] ignored (forced 0)
- mem_rd  out  1  byte read request this cycle
- mem_addr  out  64  byte address, = pc + cnt
- mem_rdata  in  8  read byte, valid the cycle after the request (synchronous memory)
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decode accepts inst this cycle
- inst  out  32  {byte3,byte2,byte1,byte0}
- inst_pc  out  64  address of inst
- busy  out  1  state is FETCH or DRAIN

## Operation
- Registers:
  - pc[63:0]
  - cnt[1:0]: issue index
  - cap_idx[1:0]: index of the in-flight byte
  - cap_vld: byte in flight
  - byte buffer 4×8
  - state
- States: IDLE, FETCH, DRAIN, VALID.
- IDLE: mem_rd=0.
  - fetch_en=1: go to FETCH with cnt=0.
- FETCH: mem_rd=1, mem_addr=pc+cnt.
  - Each cycle: cap_idx<=cnt, cap_vld<=1, cnt<=cnt+1.
  - cnt==3: go to DRAIN.
- Capture: any cycle with cap_vld=1 writes mem_rdata into buffer[cap_idx].
- DRAIN: mem_rd=0; captures byte 3, cap_vld<=0, go to VALID.
- VALID: inst_valid=1, inst=buffer, inst_pc=pc.
  - Outputs stay stable while inst_ready=0.
  - On inst_valid&&inst_ready: pc<=pc+4 (64-bit wrap).
    - fetch_en=1: go to FETCH with cnt=0.
    - Otherwise: go to IDLE.
- Redirect has the highest priority and applies in every state:
  - pc<={redirect_pc[63:2],2'b00}, cnt<=0, cap_vld<=0; the in-flight byte is discarded.
  - Next state: FETCH if fetch_en, else IDLE.
- Redirect in the same cycle as an accept: the instruction counts as consumed, and the redirect target overrides pc+4.
- fetch_en deasserted mid-fetch: the current instruction completes and is delivered; no new fetch starts.
- mem_addr carries no carry-out; pc+cnt wraps modulo 2^64.
- Reset values:
  - state=IDLE, pc=RESET_PC, cnt=0, cap_vld=0, buffer=0.
  - mem_rd=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=RESET_PC, busy=0.
- Reset asserted mid-fetch: all of the above takes effect immediately (asynchronously); no partial instruction survives.

## Timing
- Let cycle n be the first FETCH cycle (cnt=0).
- mem_rd=1 in cycles n..n+3 at addresses pc..pc+3.
- Bytes arrive in cycles n+1..n+4; DRAIN occupies cycle n+4.
- inst_valid=1 from cycle n+5 (5-cycle fetch latency).
- With inst_ready held high, the next FETCH starts at cycle n+6: one instruction per 6 cycles.
- IDLE→FETCH: 1 cycle after fetch_en is sampled high.
- Redirect sampled at edge e: the cycle after e is FETCH cnt=0 at the new pc, inst_valid=0, mem_addr=new pc.
- No combinational path from inst_ready or redirect_valid to mem_rd or mem_addr; these outputs depend on registers only.

## Test plan
- Reset release with fetch_en=1; memory bytes 03 20 00 00 at 0..3:
  - mem_addr 0,1,2,3 in cycles n..n+3.
  - inst=0x00002003, inst_pc=0, inst_valid at n+5.
- Back-to-back with inst_ready=1; bytes 83 20 00 00 at 4..7:
  - second inst=0x00002083, inst_pc=4.
  - Spacing 6 cycles.
- Backpressure: inst_ready=0 for 10 cycles:
  - inst, inst_pc and inst_valid stable.
  - mem_rd=0 throughout.
  - Accept with inst_ready=1 ⇒ next FETCH at pc+4.
- Redirect to 0x2B at cycle n+2:
  - Next cycle mem_addr=0x28 (bits cleared), bytes from 0x28..0x2B.
  - No stale byte from the aborted fetch appears in inst.
- Redirect in the same cycle as an accept:
  - Next fetch starts at the redirect target, not pc+4.
- fetch_en dropped during FETCH: the instruction is delivered, then the block enters IDLE with mem_rd=0.
- rst_n pulsed low mid-DRAIN:
  - All outputs return to their reset values immediately.
  - Refetch starts from RESET_PC.
